quotient_reconstruct_unit: RTL and testbench
============================================

Name: quotient_reconstruct_unit

Overview:
Sequential shift-add multiplier that runs the divider's inverse, result = quotient × divisor + remainder. It checks the result against the original dividend and drives the result onto the same multiplexed 4-digit seven-segment display as the divider top module. It sits downstream of the non-restoring divider as a self-check/loopback block on the board and in regression.

Parameters:
WIDTH, 4, width of quotient, divisor and expected dividend
SCAN_BITS, 16, prescaler width; the display digit advances when the prescaler wraps (benches override to 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; a new operation launches on a 0→1 transition only
quotient  input  WIDTH  multiplicand
divisor  input  WIDTH  multiplier
remainder  input  WIDTH+1  addend
expected  input  WIDTH  original dividend, used for comparison
result  output  2*WIDTH+1  quotient×divisor+remainder, registered
busy  output  1  high from LOAD through FINAL
done  output  1  high from the DONE state until the next launch or reset
match  output  1  result == zero-extended expected; valid while done=1, 0 otherwise
seg  output  7  segments gfedcba, active-low
digit  output  4  digit enables, active-low, one-hot-low

Behaviour:
- Reset (async, rst=1): state=IDLE; result=0, busy=0, done=0, match=0; accumulator, counter, start_q and prescaler cleared; digit=4'b1110; seg shows "0" (7'b1000000).
- Launch: launch = start & ~start_q, where start_q is start registered. Launches are honoured only in IDLE or DONE and ignored otherwise. A level held high never relaunches.
- FSM: IDLE → LOAD → ADD (WIDTH cycles) → FINAL → DONE; DONE → LOAD on launch.
- LOAD: latch the operands.
  - mcand = {WIDTH+1 zeros, quotient}
  - mplier = divisor
  - addend = remainder
  - acc = 0, cnt = 0
  - done = 0, match = 0
- ADD, each cycle:
  - if mplier[0], acc += mcand (2*WIDTH+1 bits)
  - mcand <<= 1, mplier >>= 1, cnt++
  - exit when cnt == WIDTH-1 on the current cycle
- FINAL: result = acc + addend, computed as an unsigned 2*WIDTH+1-bit sum. Maximum is (2^W−1)² + 2^(W+1)−1 = 256 for W=4, which fits, so no overflow is possible.
- DONE:
  - done=1, busy=0
  - match = (result == {(WIDTH+1) zeros, expected}) registered on entry
  - result held stable
- Latency: launch sampled on edge 0 → done=1 after edge WIDTH+3 (7 cycles for WIDTH=4).
- Inputs are sampled only in LOAD; changes during ADD/FINAL have no effect.
- Reset mid-operation aborts immediately to the reset values above. No partial result is kept.
- Zero operands (quotient=0 or divisor=0) still take the full WIDTH ADD cycles; the latency is fixed.
- Display:
  - free-running prescaler; on wrap, rotate digit 1110 → 1101 → 1011 → 0111 → 1110
  - digit0 = result[3:0], digit1 = result[7:4], digit2 = {3'b000, result[8]}, as hex
  - digit3 shows "E" if done & ~match, otherwise blank (7'b1111111)
  - hex font is standard, active-low
  - display scanning continues through every FSM state and is independent of the FSM

Test Plan:
1. quotient=4, divisor=3, remainder=3, expected=15, pulse start 2 cycles → busy on the cycle after launch; done=1 exactly 7 cycles after launch; result=15, match=1; result stays 15 for 300 ns.
2. quotient=15, divisor=15, remainder=31, expected=0 → result=256 (9'h100), match=0; with SCAN_BITS=2, the digit3 phase shows seg=7'b0000110 ("E") and digit2 shows "1".
3. quotient=0, divisor=15, remainder=6, expected=6 → result=6, match=1, still 7-cycle latency. Then quotient=1, divisor=0, remainder=12, expected=12 → result=12, match=1.
4. start held high 20 cycles with operands 3×2+1 → exactly one operation, result=7. A second start pulse issued mid-ADD with different operands is ignored, and result stays 7.
5. Assert rst for one cycle during the 2nd ADD cycle → all outputs return to reset values asynchronously, before the next clock edge; state IDLE. A new launch after release gives the correct result.
6. Back-to-back: launch in DONE with new operands 2×4+0 → done drops in LOAD, re-asserts 7 cycles later with result=8, match=1 for expected=8.

Source files
------------

// File: rtl/quotient_reconstruct_unit.sv
// quotient_reconstruct_unit: shift-add multiplier that rebuilds quotient*divisor+remainder and checks it against the dividend
// Ports: clk/rst (async, active-high); start launches on a rising edge; quotient, divisor, remainder and expected are
// sampled in LOAD; result is the registered product plus remainder; busy spans LOAD..FINAL; done and match hold until
// the next launch; seg/digit drive a multiplexed 4-digit active-low seven-segment display.
module quotient_reconstruct_unit #(
    parameter int WIDTH     = 4,
    parameter int SCAN_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     quotient,
    input  logic [WIDTH-1:0]     divisor,
    input  logic [WIDTH:0]       remainder,
    input  logic [WIDTH-1:0]     expected,
    output logic [2*WIDTH:0]     result,
    output logic                 busy,
    output logic                 done,
    output logic                 match,
    output logic [6:0]           seg,
    output logic [3:0]           digit
);
    localparam int RW = 2 * WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [6:0] FONT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic [2:0] {IDLE, LOAD, ADD, FINAL, DONE} state_t;

    state_t               state_q, state_d;
    logic                 start_q, launch;
    logic [RW-1:0]        mcand_q, mcand_d, acc_q, acc_d, result_q, result_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d, exp_q, exp_d;
    logic [WIDTH:0]       addend_q, addend_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 done_q, done_d, match_q, match_d;
    logic [SCAN_BITS-1:0] pre_q;
    logic [3:0]           digit_q, nib;
    logic [8:0]           disp;

    assign launch = start & ~start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            mplier_q <= '0;
            exp_q    <= '0;
            addend_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            mplier_q <= mplier_d;
            exp_q    <= exp_d;
            addend_q <= addend_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            match_q  <= match_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        result_d = result_q;
        mplier_d = mplier_q;
        exp_d    = exp_q;
        addend_d = addend_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        match_d  = match_q;
        case (state_q)
            IDLE: state_d = launch ? LOAD : IDLE;
            LOAD: begin
                mcand_d  = {{(WIDTH + 1){1'b0}}, quotient};
                mplier_d = divisor;
                addend_d = remainder;
                exp_d    = expected;
                acc_d    = '0;
                cnt_d    = '0;
                done_d   = 1'b0;
                match_d  = 1'b0;
                state_d  = ADD;
            end
            ADD: begin
                acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                state_d  = (cnt_q == CW'(WIDTH - 1)) ? FINAL : ADD;
            end
            FINAL: begin
                result_d = acc_q + RW'(addend_q);
                state_d  = DONE;
            end
            DONE: begin
                // done/match register one cycle after entry; a launch clears them at once
                done_d  = ~launch;
                match_d = ~launch & (result_q == RW'(exp_q));
                state_d = launch ? LOAD : DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign result = result_q;
    assign busy   = (state_q == LOAD) || (state_q == ADD) || (state_q == FINAL);
    assign done   = done_q;
    assign match  = match_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            digit_q <= 4'b1110;
        end else begin
            pre_q <= pre_q + 1'b1;
            if (&pre_q) digit_q <= {digit_q[2:0], digit_q[3]};
        end
    end

    assign disp  = 9'(result_q);
    assign nib   = !digit_q[0] ? disp[3:0] : !digit_q[1] ? disp[7:4] : {3'b000, disp[8]};
    assign seg   = !digit_q[3] ? ((done_q && !match_q) ? 7'b0000110 : 7'b1111111) : FONT[nib];
    assign digit = digit_q;
endmodule

// File: tb/tb_quotient_reconstruct_unit.sv
// tb_quotient_reconstruct_unit: table, hand-written and random checks of the quotient reconstruction unit
module tb_quotient_reconstruct_unit;
    typedef struct {
        logic [3:0] q;
        logic [3:0] d;
        logic [4:0] r;
        logic [3:0] e;
        logic [8:0] res;
        logic       m;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [3:0] quotient, divisor, expected;
    logic [4:0] remainder;
    logic [8:0] result;
    logic       busy, done, match;
    logic [6:0] seg;
    logic [3:0] digit;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t       tbl [5];
    logic [6:0] font [16];
    logic [3:0] rq, rd, re;
    logic [4:0] rr;
    int         model, rises, lat;
    logic       prev_busy, stable, relaunched;

    always #5 clk = ~clk;

    quotient_reconstruct_unit #(.WIDTH(4), .SCAN_BITS(2)) dut (
        .clk(clk), .rst(rst), .start(start),
        .quotient(quotient), .divisor(divisor), .remainder(remainder), .expected(expected),
        .result(result), .busy(busy), .done(done), .match(match),
        .seg(seg), .digit(digit)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] q, input logic [3:0] d, input logic [4:0] r, input logic [3:0] e,
                          input logic [8:0] xr, input logic xm, input string nm);
        int l;
        @(negedge clk);
        quotient = q; divisor = d; remainder = r; expected = e; start = 1'b1;
        @(negedge clk);
        check({nm, "_busy_after_launch"}, busy, 1);
        check({nm, "_done_after_launch"}, done, 0);
        l = 0;
        while (!done && l < 20) begin
            @(negedge clk);
            l++;
            if (l == 1) start = 1'b0;
        end
        start = 1'b0;
        check({nm, "_latency"}, l, 7);
        check({nm, "_busy_done"}, busy, 0);
        check({nm, "_result"}, result, xr);
        check({nm, "_match"}, match, xm);
    endtask

    task automatic check_disp(input logic [8:0] res, input logic err);
        logic [3:0] prev;
        logic [6:0] xs;
        logic [3:0] seen;
        prev = digit;
        seen = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (digit != prev) check("digit_rotate", digit, {prev[2:0], prev[3]});
            prev = digit;
            case (digit)
                4'b1110: begin xs = font[res[3:0]]; seen[0] = 1'b1; end
                4'b1101: begin xs = font[res[7:4]]; seen[1] = 1'b1; end
                4'b1011: begin xs = font[{3'b000, res[8]}]; seen[2] = 1'b1; end
                4'b0111: begin xs = err ? 7'b0000110 : 7'b1111111; seen[3] = 1'b1; end
                default: xs = 7'bx;
            endcase
            if (xs === 7'bx) check("digit_onehot", digit, 4'b1110);
            else check("seg", seg, xs);
        end
        check("digit_all_phases", seen, 4'b1111);
    endtask

    initial begin
        font = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        tbl = '{
            '{4'd4,  4'd3,  5'd3,  4'd15, 9'd15,  1'b1},
            '{4'd15, 4'd15, 5'd31, 4'd0,  9'd256, 1'b0},
            '{4'd0,  4'd15, 5'd6,  4'd6,  9'd6,   1'b1},
            '{4'd1,  4'd0,  5'd12, 4'd12, 9'd12,  1'b1},
            '{4'd2,  4'd4,  5'd0,  4'd8,  9'd8,   1'b1}
        };
        rst = 1'b1; start = 1'b0;
        quotient = '0; divisor = '0; remainder = '0; expected = '0;
        repeat (3) @(negedge clk);
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_match", match, 0);
        check("rst_digit", digit, 4'b1110);
        check("rst_seg", seg, 7'b1000000);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].q, tbl[i].d, tbl[i].r, tbl[i].e, tbl[i].res, tbl[i].m, $sformatf("tbl%0d", i));
            if (i == 0) begin
                stable = 1'b1;
                repeat (30) begin
                    @(negedge clk);
                    if (result !== 9'd15 || done !== 1'b1) stable = 1'b0;
                end
                check("tbl0_hold", stable, 1);
            end
            if (i == 1) check_disp(9'd256, 1'b1);
        end
        check_disp(9'd8, 1'b0);

        // start held high: exactly one operation
        @(negedge clk);
        quotient = 4'd3; divisor = 4'd2; remainder = 5'd1; expected = 4'd7; start = 1'b1;
        rises = 0; prev_busy = busy;
        repeat (20) begin
            @(negedge clk);
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        start = 1'b0;
        check("hold_busy_rises", rises, 1);
        check("hold_done", done, 1);
        check("hold_result", result, 7);
        check("hold_match", match, 1);

        // operand change and start pulse during ADD are ignored
        @(negedge clk);
        quotient = 4'd3; divisor = 4'd2; remainder = 5'd1; expected = 4'd7; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0; quotient = 4'd5; divisor = 4'd5; remainder = 5'd3; expected = 4'd0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        check("midadd_done", done, 1);
        relaunched = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (busy) relaunched = 1'b1;
        end
        check("midadd_no_relaunch", relaunched, 0);
        check("midadd_result", result, 7);
        check("midadd_match", match, 1);

        // async reset during the second ADD cycle
        @(negedge clk);
        quotient = 4'd6; divisor = 4'd7; remainder = 5'd2; expected = 4'd1; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_result", result, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_match", match, 0);
        check("arst_digit", digit, 4'b1110);
        check("arst_seg", seg, 7'b1000000);
        @(negedge clk);
        rst = 1'b0;
        run_op(4'd5, 4'd3, 5'd2, 4'd1, 9'd17, 1'b0, "post_rst");

        for (int i = 0; i < 24; i++) begin
            rq = 4'($urandom_range(0, 15));
            rd = 4'($urandom_range(0, 15));
            rr = 5'($urandom_range(0, 31));
            model = int'(rq) * int'(rd) + int'(rr);
            re = ($urandom_range(0, 1) == 1) ? model[3:0] : 4'($urandom_range(0, 15));
            run_op(rq, rd, rr, re, 9'(model), model == int'(re), $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
